regfile_mp: RTL and testbench

- Parametrised multi-read-port register file. Successor to the fixed 32x64, two-read/one-write register file in the datapath.
- Generalised in data width, depth and number of read ports.
- Adds a hardwired zero register (LEGv8 XZR) and a sequential clear engine that sweeps the array one entry per cycle.
- Sits between decode (read addresses) and writeback (write port) in the single-cycle/pipelined CPU.

---
 rtl/regfile_mp_if.sv | 27 ++
 rtl/regfile_mp.sv | 127 ++++++++++++
 tb/tb_regfile_mp.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: write port, packed read ports and clear-engine handshake.
// The master side is decode/writeback (or a bench); the slave side is the register file.
interface regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                       wrEn;
  logic [ADDR_W-1:0]          wrAddr;
  logic [DATA_W-1:0]          wrData;
  logic [NUM_RD*ADDR_W-1:0]   rdAddr;
  logic [NUM_RD*DATA_W-1:0]   rdData;
  logic                       clrReq;
  logic                       clrBusy;
  logic                       clrDone;
  logic                       wrDropped;

  modport master (
    output wrEn, wrAddr, wrData, rdAddr, clrReq,
    input  rdData, clrBusy, clrDone, wrDropped
  );

  modport slave (
    input  wrEn, wrAddr, wrData, rdAddr, clrReq,
    output rdData, clrBusy, clrDone, wrDropped
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with hardwired zero register and clear sweep.
// Optional write-to-read forwarding is compiled in with the REGFILE_BYPASS_EN macro.
module regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_mp_if.slave  bus
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam bit                ZERO_EN  = (ZERO_REG >= 0) && (ZERO_REG < DEPTH);
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_EN && (addr == ZERO_IDX);
  endfunction

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_cnt;
  logic              r_clr_busy;
  logic              r_clr_done;
  logic              r_wr_dropped;
  logic              w_wr_ok;
  logic              w_wr_drop;

  // Writes only land in IDLE; zero-register writes vanish without a drop pulse.
  assign w_wr_ok   = bus.wrEn && (r_state == ST_IDLE) && !is_zero_reg(bus.wrAddr);
  assign w_wr_drop = bus.wrEn && (r_state != ST_IDLE) && !is_zero_reg(bus.wrAddr);

  assign bus.clrBusy   = r_clr_busy;
  assign bus.clrDone   = r_clr_done;
  assign bus.wrDropped = r_wr_dropped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.clrReq) w_state_nxt = ST_SWEEP;
        else            w_state_nxt = ST_IDLE;
      end
      ST_SWEEP: begin
        if (r_cnt == LAST_IDX) w_state_nxt = ST_DONE;
        else                   w_state_nxt = ST_SWEEP;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE:  r_cnt <= '0;
        ST_SWEEP: r_cnt <= r_cnt + (ADDR_W + 1)'(1);
        ST_DONE:  r_cnt <= r_cnt;
        default:  r_cnt <= '0;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clr_busy   <= 1'b0;
      r_clr_done   <= 1'b0;
      r_wr_dropped <= 1'b0;
    end else begin
      r_clr_busy   <= (w_state_nxt == ST_SWEEP);
      r_clr_done   <= (w_state_nxt == ST_DONE);
      r_wr_dropped <= w_wr_drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == ST_SWEEP) begin
      r_mem[r_cnt[ADDR_W-1:0]] <= '0;
    end else if (w_wr_ok) begin
      r_mem[bus.wrAddr] <= bus.wrData;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;

    assign w_addr = bus.rdAddr[k*ADDR_W +: ADDR_W];
    assign bus.rdData[k*DATA_W +: DATA_W] = w_data;

    always_comb begin
      if (is_zero_reg(w_addr)) begin
        w_data = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (w_wr_ok && (w_addr == bus.wrAddr)) begin
        w_data = bus.wrData;
`endif
      end else begin
        w_data = r_mem[w_addr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp (4 read ports) against an array-based reference model.
module tb_regfile_mp;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 4;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [DW-1:0] model [32];

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(31)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    return (a == 5'd31) ? 64'd0 : model[a];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.wrEn = 1'b1; bus.wrAddr = a; bus.wrData = d;
    step();
    bus.wrEn = 1'b0;
    if (a != 5'd31) model[a] = d;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    bus.rdAddr[k*AW +: AW] = a;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    n_cmp++;
    if ({bus.clrBusy, bus.clrDone, bus.wrDropped} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 000", {bus.clrBusy, bus.clrDone, bus.wrDropped});
    end
    for (int k = 0; k < NR; k++) begin
      set_rd(k, 5'(k * 7 + 1));
      #1;
      n_cmp++;
      if (bus.rdData[k*DW +: DW] !== 64'd0) begin
        n_err++; $display("FAIL reset_read port %0d: got %h expected 0", k, bus.rdData[k*DW +: DW]);
      end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    do_write(5'd3, 64'd7);
    set_rd(0, 5'd3); set_rd(1, 5'd0);
    #1;
    n_cmp++;
    if (bus.rdData[0 +: DW] !== 64'd7) begin
      n_err++; $display("FAIL basic_rd0: got %h expected 7", bus.rdData[0 +: DW]);
    end
    n_cmp++;
    if (bus.rdData[DW +: DW] !== 64'd0) begin
      n_err++; $display("FAIL basic_rd1: got %h expected 0", bus.rdData[DW +: DW]);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    n_cmp++;
    if (bus.wrDropped !== 1'b0) begin
      n_err++; $display("FAIL zero_dropped: got %b expected 0", bus.wrDropped);
    end
    set_rd(0, 5'd31); set_rd(1, 5'd31);
    #1;
    n_cmp++;
    if (bus.rdData[2*DW-1:0] !== 128'd0) begin
      n_err++; $display("FAIL zero_read: got %h expected 0", bus.rdData[2*DW-1:0]);
    end
  endtask

  task automatic test_multiport();
    for (int i = 1; i <= 4; i++) do_write(5'(i), 64'(i * 10));
    for (int k = 0; k < NR; k++) set_rd(k, 5'(k + 1));
    #1;
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (bus.rdData[k*DW +: DW] !== 64'((k + 1) * 10)) begin
        n_err++; $display("FAIL multi_port%0d: got %0d expected %0d", k, bus.rdData[k*DW +: DW], (k + 1) * 10);
      end
    end
    for (int k = 0; k < NR; k++) set_rd(k, 5'd2);
    #1;
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (bus.rdData[k*DW +: DW] !== 64'd20) begin
        n_err++; $display("FAIL multi_same%0d: got %0d expected 20", k, bus.rdData[k*DW +: DW]);
      end
    end
  endtask

  task automatic test_rw_same();
    logic [DW-1:0] exp_now;
    do_write(5'd6, 64'd1);
    bus.wrEn = 1'b1; bus.wrAddr = 5'd6; bus.wrData = 64'd2;
    set_rd(0, 5'd6);
    #1;
    exp_now = BYP ? 64'd2 : 64'd1;
    n_cmp++;
    if (bus.rdData[0 +: DW] !== exp_now) begin
      n_err++; $display("FAIL rw_same_now: got %0d expected %0d", bus.rdData[0 +: DW], exp_now);
    end
    step();
    bus.wrEn = 1'b0;
    model[6] = 64'd2;
    n_cmp++;
    if (bus.rdData[0 +: DW] !== 64'd2) begin
      n_err++; $display("FAIL rw_same_next: got %0d expected 2", bus.rdData[0 +: DW]);
    end
  endtask

  task automatic test_random();
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra;
    logic [DW-1:0] exp_v;
    for (int it = 0; it < 80; it++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = {$urandom, $urandom};
      bus.wrEn = we; bus.wrAddr = wa; bus.wrData = wd;
      for (int k = 0; k < NR; k++) set_rd(k, 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) set_rd(0, wa);
      #1;
      for (int k = 0; k < NR; k++) begin
        ra = bus.rdAddr[k*AW +: AW];
        if (BYP && we && (wa != 5'd31) && (ra == wa)) exp_v = wd;
        else exp_v = exp_rd(ra);
        n_cmp++;
        if (bus.rdData[k*DW +: DW] !== exp_v) begin
          n_err++; $display("FAIL random it%0d port%0d addr%0d: got %h expected %h", it, k, ra, bus.rdData[k*DW +: DW], exp_v);
        end
      end
      step();
      if (we && (wa != 5'd31)) model[wa] = wd;
      n_cmp++;
      if (bus.wrDropped !== 1'b0) begin
        n_err++; $display("FAIL random_dropped it%0d: got %b expected 0", it, bus.wrDropped);
      end
    end
    bus.wrEn = 1'b0;
  endtask

  task automatic test_sweep();
    int busy_cnt;
    int done_cnt;
    int done_at;
    busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int i = 0; i < 31; i++) do_write(5'(i), 64'(i + 100));
    bus.clrReq = 1'b1;
    step();
    bus.clrReq = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.clrBusy === 1'b1) busy_cnt++;
      if (bus.clrDone === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == 3) begin
        bus.wrEn = 1'b1; bus.wrAddr = 5'd9; bus.wrData = 64'd55;
      end
      if (c == 4) begin
        bus.wrEn = 1'b0;
        n_cmp++;
        if (bus.wrDropped !== 1'b1) begin
          n_err++; $display("FAIL sweep_drop_pulse: got %b expected 1", bus.wrDropped);
        end
      end
      if (c == 5) begin
        n_cmp++;
        if (bus.wrDropped !== 1'b0) begin
          n_err++; $display("FAIL sweep_drop_single: got %b expected 0", bus.wrDropped);
        end
      end
      if (c == 16) begin
        set_rd(0, 5'd5); set_rd(1, 5'd20);
        #1;
        n_cmp++;
        if (bus.rdData[0 +: DW] !== 64'd0) begin
          n_err++; $display("FAIL sweep_mid_reg5: got %0d expected 0", bus.rdData[0 +: DW]);
        end
        n_cmp++;
        if (bus.rdData[DW +: DW] !== 64'd120) begin
          n_err++; $display("FAIL sweep_mid_reg20: got %0d expected 120", bus.rdData[DW +: DW]);
        end
      end
      step();
    end
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    n_cmp++;
    if (busy_cnt != 32) begin
      n_err++; $display("FAIL sweep_busy_len: got %0d expected 32", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 1 || done_at != 32) begin
      n_err++; $display("FAIL sweep_done: got %0d pulses at %0d expected 1 at 32", done_cnt, done_at);
    end
    for (int i = 0; i < 32; i += NR) begin
      for (int k = 0; k < NR; k++) set_rd(k, 5'(i + k));
      #1;
      for (int k = 0; k < NR; k++) begin
        n_cmp++;
        if (bus.rdData[k*DW +: DW] !== exp_rd(5'(i + k))) begin
          n_err++; $display("FAIL sweep_after reg%0d: got %h expected 0", i + k, bus.rdData[k*DW +: DW]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_write(5'd20, 64'h1234);
    bus.clrReq = 1'b1;
    step();
    bus.clrReq = 1'b0;
    repeat (10) step();
    set_rd(0, 5'd20);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) model[i] = 64'd0;
    n_cmp++;
    if (bus.clrBusy !== 1'b0) begin
      n_err++; $display("FAIL rst_mid_busy: got %b expected 0", bus.clrBusy);
    end
    n_cmp++;
    if (bus.rdData[0 +: DW] !== 64'd0) begin
      n_err++; $display("FAIL rst_mid_reg20: got %h expected 0", bus.rdData[0 +: DW]);
    end
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++;
      if ({bus.clrBusy, bus.clrDone} !== 2'b00) begin
        n_err++; $display("FAIL rst_mid_idle c%0d: got %b expected 00", c, {bus.clrBusy, bus.clrDone});
      end
    end
    do_write(5'd8, 64'd77);
    set_rd(0, 5'd8);
    #1;
    n_cmp++;
    if (bus.rdData[0 +: DW] !== 64'd77) begin
      n_err++; $display("FAIL rst_mid_write_after: got %0d expected 77", bus.rdData[0 +: DW]);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b1;
    bus.wrEn = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
    bus.rdAddr = '0; bus.clrReq = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_zero_reg();
    test_multiport();
    test_rw_same();
    test_random();
    test_sweep();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
